bus_timer_responder: RTL and testbench
======================================

// Module: bus_timer_responder
// PURPOSE
//  Memory-mapped machine-timer peripheral. It is the responder on the data bus driven by the memory-access stage
//  (bus_re / bus_we[3:0] / bus_addr / bus_wdata -> bus_rdata).
//  It holds a 64-bit free-running counter (mtime), a 64-bit compare value (mtimecmp), control and status registers.
//  When mtime >= mtimecmp it sets a sticky pending flag and can raise timer_irq to the core.
// PARAMETERS
//  BASE_ADDR  32'h1000_0000  region base; must be 32-byte aligned; decoded window is BASE_ADDR..BASE_ADDR+0x1F
// PORTS
//  clk        in   1   single clock; all state updates on its rising edge
//  rst        in   1   synchronous, active-high reset
//  bus_re     in   1   read strobe from the initiator
//  bus_we     in   4   byte-lane write enables; lane i = bus_wdata[8i+7:8i]
//  bus_addr   in   32  byte address; bits [1:0] ignored
//  bus_wdata  in   32  write data
//  bus_rdata  out  32  read data, combinational, valid in the same cycle as bus_re
//  timer_irq  out  1   registered interrupt request = pending & irq_en
// BEHAVIOUR
//  Decode
//  - hit = (bus_addr[31:5] == BASE_ADDR[31:5]); off = bus_addr[4:2].
//  - No wait states and no handshake: a write commits on the clock edge of its cycle.
//  - Read: bus_rdata = reg[off] when (bus_re & hit & off<=5); otherwise 32'h0.
//  - Writes to a miss or to off 6/7 are ignored. Reads have no side effects.
//  Register map (offset: name, reset value)
//  - 0x00 MTIME_LO (0)       0x04 MTIME_HI (0)
//  - 0x08 CMP_LO (FFFF_FFFF) 0x0C CMP_HI (FFFF_FFFF)
//  - 0x10 CTRL (0): [0] en, [1] irq_en, [15:8] prescale; other bits read 0, writes dropped
//  - 0x14 STATUS (0): [0] pending, write-1-to-clear via lane 0; other bits read 0
//  - Byte-lane writes: only the enabled lanes change; all other bytes hold.
//  Prescaler / counting
//  - 8-bit pcnt, reset 0. While en=1: tick when pcnt==prescale, then pcnt<=0; else pcnt<=pcnt+1.
//  - While en=0: pcnt<=0 and no tick.
//  - So prescale=0 gives a tick every cycle, and prescale=N gives one tick every N+1 cycles.
//  - On tick, mtime <= mtime+1 as a full 64-bit add (LO->HI carry); FFFF..FF wraps to 0.
//  - Any write to MTIME_LO or MTIME_HI in a cycle suppresses that cycle's increment.
//    The written bytes take bus_wdata and the unwritten bytes hold; the prescaler still advances.
//  - A write to CTRL.prescale takes effect the next cycle; pcnt is not reset.
//  Compare / interrupt
//  - match = (mtime >= mtimecmp), unsigned 64-bit, computed on the current registered values.
//  - pending <= match | (pending & ~w1c), so a set wins over a simultaneous clear.
//  - After a clear, pending re-asserts the next cycle if match still holds.
//  - timer_irq <= pending_next & irq_en_next, registered, so it follows pending by 0 cycles of lag past the flop.
//  - irq_en does not gate pending.
//  Reset
//  - rst has priority over every bus access.
//  - Clears mtime, CTRL, pending, pcnt and timer_irq; sets mtimecmp to all-ones.
//  - bus_rdata is combinational and reads the reset values from the cycle after reset.
//  - Reset asserted mid-count discards the count and pending state.
// TESTING
//  - Reset, then read offsets 0x00..0x1C -> 0,0,FFFF_FFFF,FFFF_FFFF,0,0,0,0; timer_irq=0; a miss address reads 0.
//  - CTRL=0x0000_0301 (en, prescale=3), run 40 cycles -> MTIME_LO=10; en=0 -> MTIME_LO frozen.
//  - MTIME_LO=FFFF_FFFE, MTIME_HI=0, prescale=0, en=1 -> after 2 ticks HI=1, LO=0.
//    A bus_we=4'b0010 write of 0x0000_AB00 to LO changes only byte 1, and no increment happens in that cycle.
//  - CMP=0x0000_0000_0000_0005, CTRL=0x3 -> pending and timer_irq rise once mtime reaches 5.
//    STATUS W1C while mtime>=5 -> pending re-asserts the next cycle.
//    Raising CMP to 100, then W1C -> pending=0, timer_irq=0.
//  - W1C to STATUS in the same cycle match becomes true -> pending=1.
//    rst in the middle of a count -> all registers at reset values the next cycle.

Source files
------------

// File: rtl/bus_timer_responder.sv
// Memory-mapped machine timer: 64-bit mtime with prescaler, 64-bit compare,
// sticky pending flag and registered interrupt request.
module bus_timer_responder #(
   parameter logic [31:0] BASE_ADDR = 32'h1000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        bus_re,
   input  logic [3:0]  bus_we,
   input  logic [31:0] bus_addr,
   input  logic [31:0] bus_wdata,
   output logic [31:0] bus_rdata,
   output logic        timer_irq
);

   logic [63:0] mtime_q, mtime_d;
   logic [63:0] cmp_q, cmp_d;
   logic        en_q, en_d;
   logic        irq_en_q, irq_en_d;
   logic [7:0]  prescale_q, prescale_d;
   logic [7:0]  pcnt_q, pcnt_d;
   logic        pending_q, pending_d;
   logic        irq_q, irq_d;

   logic        hit, wr, match, tick, w1c;
   logic [2:0]  off;
   logic        addr_unused;

   assign addr_unused = ^bus_addr[1:0];

   function automatic logic [31:0] merge_lanes(input logic [31:0] old,
                                               input logic [31:0] wd,
                                               input logic [3:0]  be);
      logic [31:0] r;
      r = old;
      for (int unsigned i = 0; i < 4; i++) begin
         if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
      end
      return r;
   endfunction

   always_comb begin
      hit        = (bus_addr[31:5] == BASE_ADDR[31:5]);
      off        = bus_addr[4:2];
      wr         = hit && (bus_we != 4'b0000);
      match      = (mtime_q >= cmp_q);
      tick       = en_q && (pcnt_q == prescale_q);
      w1c        = 1'b0;

      pcnt_d     = en_q ? (tick ? '0 : pcnt_q + 8'd1) : '0;
      mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
      cmp_d      = cmp_q;
      en_d       = en_q;
      irq_en_d   = irq_en_q;
      prescale_d = prescale_q;

      // A bus write to either mtime half replaces this cycle's increment.
      if (wr) begin
         case (off)
            3'd0: mtime_d = {mtime_q[63:32], merge_lanes(mtime_q[31:0], bus_wdata, bus_we)};
            3'd1: mtime_d = {merge_lanes(mtime_q[63:32], bus_wdata, bus_we), mtime_q[31:0]};
            3'd2: cmp_d   = {cmp_q[63:32], merge_lanes(cmp_q[31:0], bus_wdata, bus_we)};
            3'd3: cmp_d   = {merge_lanes(cmp_q[63:32], bus_wdata, bus_we), cmp_q[31:0]};
            3'd4: begin
               if (bus_we[0]) begin
                  en_d     = bus_wdata[0];
                  irq_en_d = bus_wdata[1];
               end
               if (bus_we[1]) prescale_d = bus_wdata[15:8];
            end
            3'd5: w1c = bus_we[0] & bus_wdata[0];
            default: ;
         endcase
      end

      pending_d = match | (pending_q & ~w1c);
      irq_d     = pending_d & irq_en_d;
   end

   always_comb begin
      bus_rdata = '0;
      if (bus_re && hit) begin
         case (off)
            3'd0: bus_rdata = mtime_q[31:0];
            3'd1: bus_rdata = mtime_q[63:32];
            3'd2: bus_rdata = cmp_q[31:0];
            3'd3: bus_rdata = cmp_q[63:32];
            3'd4: bus_rdata = {16'h0000, prescale_q, 6'b000000, irq_en_q, en_q};
            3'd5: bus_rdata = {31'h0, pending_q};
            default: bus_rdata = '0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mtime_q    <= '0;
         cmp_q      <= '1;
         en_q       <= 1'b0;
         irq_en_q   <= 1'b0;
         prescale_q <= '0;
         pcnt_q     <= '0;
         pending_q  <= 1'b0;
         irq_q      <= 1'b0;
      end else begin
         mtime_q    <= mtime_d;
         cmp_q      <= cmp_d;
         en_q       <= en_d;
         irq_en_q   <= irq_en_d;
         prescale_q <= prescale_d;
         pcnt_q     <= pcnt_d;
         pending_q  <= pending_d;
         irq_q      <= irq_d;
      end
   end

   assign timer_irq = irq_q;

endmodule

// File: tb/tb_bus_timer_responder.sv
// Self-checking bench for bus_timer_responder: directed scenarios plus
// randomized bus traffic compared against a cycle-level behavioural model.
module tb_bus_timer_responder;

   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        bus_re = 1'b0;
   logic [3:0]  bus_we = 4'b0000;
   logic [31:0] bus_addr = 32'h0;
   logic [31:0] bus_wdata = 32'h0;
   logic [31:0] bus_rdata;
   logic        timer_irq;

   int errors = 0;
   int checks = 0;

   bus_timer_responder #(.BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .bus_re(bus_re), .bus_we(bus_we),
      .bus_addr(bus_addr), .bus_wdata(bus_wdata),
      .bus_rdata(bus_rdata), .timer_irq(timer_irq)
   );

   always #5 clk = ~clk;

   // ---------------- behavioural reference model ----------------
   logic [63:0] m_mtime = 64'h0;
   logic [63:0] m_cmp = '1;
   logic [31:0] m_ctrl = 32'h0;
   int          m_pcnt = 0;
   bit          m_pend = 0;
   bit          m_irq = 0;

   function automatic logic [31:0] lanes(input logic [31:0] old, input logic [31:0] wd,
                                         input logic [3:0] be);
      logic [31:0] r;
      r = old;
      for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
      return r;
   endfunction

   function automatic logic [31:0] m_read(input logic re, input logic [31:0] addr);
      if (!re || addr[31:5] != BASE[31:5]) return 32'h0;
      case (addr[4:2])
         3'd0: return m_mtime[31:0];
         3'd1: return m_mtime[63:32];
         3'd2: return m_cmp[31:0];
         3'd3: return m_cmp[63:32];
         3'd4: return m_ctrl;
         3'd5: return {31'h0, m_pend};
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_step();
      logic [63:0] nt, nc;
      logic [31:0] nctrl;
      bit hit, wrt, tick, match, w1c, en;
      int pre;
      if (rst) begin
         m_mtime = 64'h0; m_cmp = '1; m_ctrl = 32'h0;
         m_pcnt = 0; m_pend = 0; m_irq = 0;
         return;
      end
      hit   = (bus_addr[31:5] == BASE[31:5]);
      wrt   = hit && (bus_we != 4'b0000);
      en    = m_ctrl[0];
      pre   = int'(m_ctrl[15:8]);
      tick  = en && (m_pcnt == pre);
      match = (m_mtime >= m_cmp);
      w1c   = 0;
      nt    = tick ? m_mtime + 64'd1 : m_mtime;
      nc    = m_cmp;
      nctrl = m_ctrl;
      if (wrt) begin
         case (bus_addr[4:2])
            3'd0: nt = {m_mtime[63:32], lanes(m_mtime[31:0], bus_wdata, bus_we)};
            3'd1: nt = {lanes(m_mtime[63:32], bus_wdata, bus_we), m_mtime[31:0]};
            3'd2: nc[31:0] = lanes(m_cmp[31:0], bus_wdata, bus_we);
            3'd3: nc[63:32] = lanes(m_cmp[63:32], bus_wdata, bus_we);
            3'd4: nctrl = lanes(m_ctrl, bus_wdata, bus_we) & 32'h0000_FF03;
            3'd5: w1c = bus_we[0] && bus_wdata[0];
            default: ;
         endcase
      end
      m_pcnt  = (!en || tick) ? 0 : m_pcnt + 1;
      m_mtime = nt;
      m_cmp   = nc;
      m_ctrl  = nctrl;
      m_pend  = match || (m_pend && !w1c);
      m_irq   = m_pend && m_ctrl[1];
   endtask

   always @(posedge clk) model_step();

   // ---------------- bus helpers ----------------
   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
   endtask

   task automatic wr(input logic [4:0] off, input logic [3:0] we, input logic [31:0] d);
      @(negedge clk);
      bus_addr = BASE + {27'h0, off};
      bus_we = we;
      bus_wdata = d;
      @(posedge clk);
      #1 bus_we = 4'b0000;
   endtask

   task automatic rd(input logic [31:0] addr, output logic [31:0] v);
      @(negedge clk);
      bus_re = 1'b1;
      bus_addr = addr;
      #1 v = bus_rdata;
      bus_re = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      logic [31:0] v;
      logic [31:0] exp_tab [8];
      exp_tab = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 32'h0, 32'h0};
      do_reset();
      for (int i = 0; i < 8; i++) begin
         rd(BASE + 32'(i * 4), v);
         checks++;
         if (v !== exp_tab[i] || v !== m_read(1'b1, BASE + 32'(i * 4))) begin
            errors++;
            $display("FAIL reset_read off=%0h got=%h exp=%h", i * 4, v, exp_tab[i]);
         end
      end
      checks++;
      if (timer_irq !== 1'b0) begin
         errors++;
         $display("FAIL reset_irq got=%b exp=0", timer_irq);
      end
      rd(BASE + 32'h20, v);
      checks++;
      if (v !== 32'h0) begin
         errors++;
         $display("FAIL miss_read got=%h exp=00000000", v);
      end
   endtask

   task automatic test_prescale();
      logic [31:0] v;
      do_reset();
      wr(5'h10, 4'hF, 32'h0000_0301);
      repeat (40) @(posedge clk);
      wr(5'h10, 4'hF, 32'h0000_0000);
      rd(BASE, v);
      checks++;
      if (v !== 32'd10 || v !== m_mtime[31:0]) begin
         errors++;
         $display("FAIL prescale_count got=%0d exp=10", v);
      end
      repeat (10) @(posedge clk);
      rd(BASE, v);
      checks++;
      if (v !== 32'd10) begin
         errors++;
         $display("FAIL prescale_frozen got=%0d exp=10", v);
      end
   endtask

   task automatic test_carry();
      logic [31:0] hi, lo;
      do_reset();
      wr(5'h00, 4'hF, 32'hFFFF_FFFE);
      wr(5'h04, 4'hF, 32'h0);
      wr(5'h10, 4'hF, 32'h1);
      @(posedge clk);
      wr(5'h10, 4'hF, 32'h0);
      rd(BASE + 32'h4, hi);
      rd(BASE, lo);
      checks++;
      if (hi !== 32'h1 || lo !== 32'h0) begin
         errors++;
         $display("FAIL carry got=%h_%h exp=00000001_00000000", hi, lo);
      end
   endtask

   task automatic test_byte_lane();
      logic [31:0] v;
      do_reset();
      wr(5'h00, 4'hF, 32'h1122_3344);
      wr(5'h10, 4'hF, 32'h1);
      wr(5'h00, 4'b0010, 32'h0000_AB00);
      rd(BASE, v);
      checks++;
      if (v !== 32'h1122_AB44 || v !== m_mtime[31:0]) begin
         errors++;
         $display("FAIL byte_lane got=%h exp=1122ab44", v);
      end
      wr(5'h10, 4'hF, 32'h0);
      rd(BASE + 32'h4, v);
      checks++;
      if (v !== 32'h0 || v !== m_mtime[63:32]) begin
         errors++;
         $display("FAIL byte_lane_hi got=%h exp=00000000", v);
      end
   endtask

   task automatic test_compare_irq();
      logic [31:0] v;
      do_reset();
      wr(5'h08, 4'hF, 32'd5);
      wr(5'h0C, 4'hF, 32'd0);
      wr(5'h10, 4'hF, 32'h3);
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         checks++;
         if (timer_irq !== (k >= 6) || timer_irq !== m_irq) begin
            errors++;
            $display("FAIL cmp_irq k=%0d got=%b exp=%b", k, timer_irq, k >= 6);
         end
      end
      wr(5'h14, 4'h1, 32'h1);
      rd(BASE + 32'h14, v);
      checks++;
      if (v !== 32'h1 || timer_irq !== 1'b1) begin
         errors++;
         $display("FAIL w1c_rearm got=%h irq=%b exp=1 irq=1", v, timer_irq);
      end
      wr(5'h10, 4'hF, 32'h2);
      wr(5'h08, 4'hF, 32'd100);
      wr(5'h14, 4'h1, 32'h1);
      rd(BASE + 32'h14, v);
      checks++;
      if (v !== 32'h0 || timer_irq !== 1'b0 || v !== m_read(1'b1, BASE + 32'h14)) begin
         errors++;
         $display("FAIL w1c_clear got=%h irq=%b exp=0 irq=0", v, timer_irq);
      end
   endtask

   task automatic test_w1c_race();
      logic [31:0] v;
      do_reset();
      wr(5'h08, 4'hF, 32'd5);
      wr(5'h0C, 4'hF, 32'd0);
      wr(5'h00, 4'hF, 32'd4);
      wr(5'h10, 4'hF, 32'h1);
      @(posedge clk);
      wr(5'h14, 4'h1, 32'h1);
      rd(BASE + 32'h14, v);
      checks++;
      if (v !== 32'h1) begin
         errors++;
         $display("FAIL w1c_race got=%h exp=00000001", v);
      end
   endtask

   task automatic test_reset_midcount();
      logic [31:0] v;
      logic [31:0] exp_tab [6];
      exp_tab = '{32'h0, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0};
      do_reset();
      wr(5'h0C, 4'hF, 32'd0);
      wr(5'h08, 4'hF, 32'd2);
      wr(5'h10, 4'hF, 32'h0000_0103);
      repeat (20) @(posedge clk);
      do_reset();
      for (int i = 0; i < 6; i++) begin
         rd(BASE + 32'(i * 4), v);
         checks++;
         if (v !== exp_tab[i]) begin
            errors++;
            $display("FAIL midreset_read off=%0h got=%h exp=%h", i * 4, v, exp_tab[i]);
         end
      end
      checks++;
      if (timer_irq !== 1'b0) begin
         errors++;
         $display("FAIL midreset_irq got=%b exp=0", timer_irq);
      end
   endtask

   task automatic test_random();
      logic [31:0] exp;
      int off;
      do_reset();
      for (int n = 0; n < 500; n++) begin
         @(negedge clk);
         off = $urandom_range(0, 7);
         bus_re = 1'($urandom);
         if ($urandom_range(0, 7) == 0)
            bus_addr = BASE + 32'h20 + ($urandom & 32'h0000_FFFF);
         else
            bus_addr = BASE + 32'(off * 4) + ($urandom & 32'h3);
         bus_we = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
         case (off)
            0, 2: bus_wdata = $urandom_range(0, 200);
            1, 3: bus_wdata = ($urandom_range(0, 3) == 0) ? $urandom : 32'h0;
            4: bus_wdata = $urandom & 32'hFFFF_03FF;
            default: bus_wdata = $urandom;
         endcase
         #1;
         exp = m_read(bus_re, bus_addr);
         checks++;
         if (bus_rdata !== exp || timer_irq !== m_irq) begin
            errors++;
            $display("FAIL random n=%0d addr=%h rdata=%h exp=%h irq=%b exp_irq=%b",
                     n, bus_addr, bus_rdata, exp, timer_irq, m_irq);
         end
      end
      @(negedge clk);
      bus_re = 1'b0;
      bus_we = 4'h0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout got=running exp=finished");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_prescale();
      test_carry();
      test_byte_lane();
      test_compare_irq();
      test_w1c_race();
      test_reset_midcount();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
